fifo_stream_reader: RTL

//  Read-side master for sync_fifo. Drives re and consumes r_data/empty, then presents the words
//  as a valid/ready stream to a downstream consumer. Prefetches through a 2-entry output buffer,
//  so the stream sustains 1 word/cycle despite the FIFO's registered read port.

---
 rtl/fifo_pkg.sv | 8 +
 rtl/stream_buf2.sv | 48 ++++
 rtl/fifo_stream_reader.sv | 66 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Types and constants shared by sync_fifo users and the stream reader.
package fifo_pkg;

   typedef logic [1:0] occ_t;

   localparam int BufDepth = 2;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry register buffer with 1-bit head/tail pointers.
// Wrap-around is a pointer toggle.
module stream_buf2
   import fifo_pkg::*;
#(
   parameter type T = logic [31:0]
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output logic valid,
   output T     data,
   output occ_t occ
);

   T     entry [BufDepth];
   logic head;
   logic tail;

   // NOTE: payload storage has no reset; occ decides visibility, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) entry[tail] <= push_data;
   end

   // NOTE: state registers use non-blocking assignments so every reader sees the pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= 1'b0;
         tail <= 1'b0;
         occ  <= '0;
      end else if (clr) begin
         head <= 1'b0;
         tail <= 1'b0;
         occ  <= '0;
      end else begin
         if (push) tail <= ~tail;
         if (pop)  head <= ~head;
         occ <= occ + occ_t'(push) - occ_t'(pop);
      end
   end

   assign valid = (occ != '0);
   assign data  = entry[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for sync_fifo: prefetches through a 2-entry buffer and
// presents the words as a valid/ready stream at up to one word per cycle.
module fifo_stream_reader
   import fifo_pkg::occ_t;
#(
   parameter type T        = logic [31:0],
   parameter int  BufDepth = fifo_pkg::BufDepth
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   output logic fifo_re,
   input  T     fifo_r_data,
   input  logic fifo_empty,
   output logic out_valid,
   output T     out_data,
   input  logic out_ready,
   output occ_t level
);

   if (BufDepth != 2) begin : g_depth_check
      $error("fifo_stream_reader: BufDepth must be 2");
   end

   logic       in_flight;
   logic       hs;
   logic [2:0] pending;
   occ_t       occ;

   assign hs = out_valid & out_ready;

   // A read is only issued if the word it returns is guaranteed a free slot.
   always_comb begin
      pending = {1'b0, occ} + {2'b0, in_flight} - {2'b0, hs};
      fifo_re = !fifo_empty && !flush && (pending <= 3'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_flight <= 1'b0;
      else        in_flight <= fifo_re;
   end

   stream_buf2 #(.T(T)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (flush),
      .push      (in_flight & ~flush),
      .push_data (fifo_r_data),
      .pop       (hs & ~flush),
      .valid     (out_valid),
      .data      (out_data),
      .occ       (occ)
   );

   assign level = occ;

   a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_re && fifo_empty));

   a_no_overfill: assert property (@(posedge clk) disable iff (!rst_n)
      ({1'b0, occ} + {2'b0, in_flight}) <= 3'd2);

   a_stable_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule
